// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, absolute or relative branch via an external
// target LUT, run/halt/done sequencing and a saturating taken-branch counter.
module pc_sequencer #(
  parameter int D  = 12,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          BranchEn,
  input  logic          BranchCond,
  input  logic          RelMode,
  input  logic [2:0]    BranchIdx,
  output logic [2:0]    LutAddr,
  input  logic [D-1:0]  LutTarget,
  output logic [D-1:0]  PC,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] TakenCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [D-1:0]  pc_q;
  logic [D-1:0]  pc_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          running_q;
  logic          done_q;
  logic          taken;

  // The LUT round trip stays combinational so a branch resolves in the same cycle.
  assign LutAddr = BranchIdx;

  always_comb begin
    taken = BranchEn & BranchCond;
    pc_d  = pc_q + D'(1);
    if (taken) begin
      pc_d = RelMode ? (pc_q + LutTarget) : LutTarget;
    end
    cnt_d = cnt_q;
    if (taken && !(&cnt_q)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_q   <= S_RUN;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        S_RUN: begin
          if (!Stall) begin
            if (Halt) begin
              state_q   <= S_DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              pc_q  <= pc_d;
              cnt_q <= cnt_d;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign PC         = pc_q;
  assign Running    = running_q;
  assign Done       = done_q;
  assign TakenCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized cycles
// compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Stall, Halt, BranchEn, BranchCond, RelMode;
  logic [2:0]  BranchIdx;
  logic [2:0]  LutAddr;
  logic [11:0] LutTarget;
  logic [11:0] PC;
  logic        Running, Done;
  logic [7:0]  TakenCount;

  int ntests = 0;
  int nfail  = 0;

  // Model: mode 0 = idle, 1 = running, 2 = done
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;

  pc_sequencer #(.D(12), .CW(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .BranchCond(BranchCond), .RelMode(RelMode),
    .BranchIdx(BranchIdx), .LutAddr(LutAddr), .LutTarget(LutTarget),
    .PC(PC), .Running(Running), .Done(Done), .TakenCount(TakenCount)
  );

  always #5 Clk = ~Clk;

  task automatic quiet();
    Reset = 0; Start = 0; Stall = 0; Halt = 0;
    BranchEn = 0; BranchCond = 0; RelMode = 0;
    BranchIdx = 3'd0; LutTarget = 12'd0;
  endtask

  // Advance one clock; the model applies the rules to the inputs present at the edge.
  task automatic step();
    @(posedge Clk);
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0;
    end else if (m_mode != 1) begin
      if (Start) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
    end else if (!Stall) begin
      if (Halt) m_mode = 2;
      else if (BranchEn && BranchCond) begin
        m_pc  = RelMode ? (m_pc + int'(LutTarget)) % 4096 : int'(LutTarget);
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else m_pc = (m_pc + 1) % 4096;
    end
    #1;
  endtask

  task automatic do_start();
    quiet(); Start = 1; step(); quiet();
  endtask

  task automatic goto_pc(input int v);
    quiet(); BranchEn = 1; BranchCond = 1; LutTarget = 12'(v); step(); quiet();
  endtask

  task automatic test_reset();
    quiet(); Reset = 1; step(); quiet();
    ntests++; if (PC !== 12'd0) begin nfail++; $display("FAIL reset_pc got %0d exp 0", PC); end
    ntests++; if (Running !== 1'b0 || Done !== 1'b0) begin nfail++; $display("FAIL reset_flags got R=%b D=%b exp 0 0", Running, Done); end
    ntests++; if (TakenCount !== 8'd0) begin nfail++; $display("FAIL reset_cnt got %0d exp 0", TakenCount); end
    for (int i = 0; i < 8; i++) begin
      Stall = 1'($urandom); Halt = 1'($urandom); BranchEn = 1; BranchCond = 1;
      LutTarget = 12'($urandom); step();
    end
    quiet();
    ntests++; if (PC !== 12'd0 || Running !== 1'b0) begin nfail++; $display("FAIL idle_ignore got pc=%0d R=%b exp 0 0", PC, Running); end
  endtask

  task automatic test_reset_mid_run();
    do_start();
    for (int i = 0; i < 4; i++) goto_pc(100 + i);
    goto_pc(37);
    ntests++; if (PC !== 12'd37 || TakenCount !== 8'd5) begin nfail++; $display("FAIL pre_reset got pc=%0d cnt=%0d exp 37 5", PC, TakenCount); end
    Reset = 1; BranchEn = 1; BranchCond = 1; LutTarget = 12'd9; step(); quiet();
    ntests++; if (PC !== 12'd0 || TakenCount !== 8'd0 || Running !== 1'b0 || Done !== 1'b0) begin
      nfail++; $display("FAIL mid_reset got pc=%0d cnt=%0d R=%b D=%b exp 0 0 0 0", PC, TakenCount, Running, Done);
    end
    do_start();
    ntests++; if (PC !== 12'd0 || Running !== 1'b1) begin nfail++; $display("FAIL start got pc=%0d R=%b exp 0 1", PC, Running); end
    for (int i = 1; i <= 3; i++) begin
      step();
      ntests++; if (PC !== 12'(i)) begin nfail++; $display("FAIL incr got %0d exp %0d", PC, i); end
    end
  endtask

  task automatic test_abs_branch();
    do_start();
    for (int i = 0; i < 10; i++) step();
    BranchIdx = 3'd3; #1;
    ntests++; if (LutAddr !== 3'd3) begin nfail++; $display("FAIL lut_addr got %0d exp 3", LutAddr); end
    BranchEn = 1; BranchCond = 1; RelMode = 0; LutTarget = 12'd53; step(); quiet();
    ntests++; if (PC !== 12'd53 || TakenCount !== 8'd1) begin nfail++; $display("FAIL abs_branch got pc=%0d cnt=%0d exp 53 1", PC, TakenCount); end
    goto_pc(10);
    BranchIdx = 3'd3; BranchEn = 1; BranchCond = 0; LutTarget = 12'd53; step(); quiet();
    ntests++; if (PC !== 12'd11 || TakenCount !== 8'd2) begin nfail++; $display("FAIL not_taken got pc=%0d cnt=%0d exp 11 2", PC, TakenCount); end
  endtask

  task automatic test_rel_branch();
    int base[4] = '{4, 4, 12'hFFE, 0};
    int off[4]  = '{12'hFFF, 20, 5, 0};
    int exp_pc[4] = '{3, 24, 3, 0};
    do_start();
    for (int i = 0; i < 4; i++) begin
      goto_pc(base[i]);
      if (i == 3) begin goto_pc(12'hFFF); step(); end
      else begin
        BranchEn = 1; BranchCond = 1; RelMode = 1; LutTarget = 12'(off[i]); step(); quiet();
      end
      ntests++; if (PC !== 12'(exp_pc[i])) begin nfail++; $display("FAIL rel_%0d got %0d exp %0d", i, PC, exp_pc[i]); end
    end
  endtask

  task automatic test_stall();
    int c0;
    do_start(); goto_pc(75); c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      Stall = 1; Halt = 1; BranchEn = 1; BranchCond = 1; LutTarget = 12'd500; step();
      ntests++; if (PC !== 12'd75 || Done !== 1'b0 || TakenCount !== 8'(c0)) begin
        nfail++; $display("FAIL stall_%0d got pc=%0d D=%b cnt=%0d exp 75 0 %0d", i, PC, Done, TakenCount, c0);
      end
    end
    Stall = 0; step(); quiet();
    ntests++; if (PC !== 12'd75 || Done !== 1'b1 || Running !== 1'b0) begin
      nfail++; $display("FAIL stall_release got pc=%0d D=%b R=%b exp 75 1 0", PC, Done, Running);
    end
  endtask

  task automatic test_halt_restart();
    do_start(); goto_pc(110);
    Halt = 1; step(); quiet();
    ntests++; if (Done !== 1'b1 || PC !== 12'd110) begin nfail++; $display("FAIL halt got D=%b pc=%0d exp 1 110", Done, PC); end
    for (int i = 0; i < 10; i++) begin
      BranchEn = 1; BranchCond = 1; RelMode = 1'($urandom); LutTarget = 12'($urandom); step();
      ntests++; if (Done !== 1'b1 || PC !== 12'd110 || TakenCount !== 8'd1) begin
        nfail++; $display("FAIL done_hold got D=%b pc=%0d cnt=%0d exp 1 110 1", Done, PC, TakenCount);
      end
    end
    do_start();
    ntests++; if (Running !== 1'b1 || Done !== 1'b0 || PC !== 12'd0 || TakenCount !== 8'd0) begin
      nfail++; $display("FAIL restart got R=%b D=%b pc=%0d cnt=%0d exp 1 0 0 0", Running, Done, PC, TakenCount);
    end
  endtask

  task automatic test_saturation();
    do_start();
    for (int i = 0; i < 260; i++) begin
      BranchEn = 1; BranchCond = 1; RelMode = 1'($urandom); LutTarget = 12'($urandom); step();
      ntests++; if (PC !== 12'(m_pc)) begin nfail++; $display("FAIL sat_pc_%0d got %0d exp %0d", i, PC, m_pc); end
    end
    quiet();
    ntests++; if (TakenCount !== 8'd255) begin nfail++; $display("FAIL saturate got %0d exp 255", TakenCount); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom_range(0, 49) == 0); Start = ($urandom_range(0, 9) == 0);
      Stall = ($urandom_range(0, 4) == 0); Halt = ($urandom_range(0, 14) == 0);
      BranchEn = 1'($urandom); BranchCond = 1'($urandom); RelMode = 1'($urandom);
      BranchIdx = 3'($urandom); LutTarget = 12'($urandom);
      #1;
      ntests++; if (LutAddr !== BranchIdx) begin nfail++; $display("FAIL rnd_lutaddr got %0d exp %0d", LutAddr, BranchIdx); end
      step();
      ntests++; if (PC !== 12'(m_pc) || TakenCount !== 8'(m_cnt) || Running !== (m_mode == 1) || Done !== (m_mode == 2)) begin
        nfail++; $display("FAIL rnd_%0d got pc=%0d cnt=%0d R=%b D=%b exp %0d %0d %0d %0d",
                          i, PC, TakenCount, Running, Done, m_pc, m_cnt, m_mode == 1, m_mode == 2);
      end
    end
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_reset_mid_run();
    test_abs_branch();
    test_rel_branch();
    test_stall();
    test_halt_restart();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
